trap_controller: RTL and testbench

Trap and interrupt sequencer for the user-mode CSR file. Watches the retiring instruction for synchronous exceptions, latches asynchronous interrupt requests, picks the highest-priority event and performs the trap. Performing a trap means one simultaneous write of uepc/ucause/utval, a pipeline flush and a PC redirect to utvec. It also executes URET by redirecting to uepc.

---
 rtl/trap_controller.sv | 150 +++++++++++++++
 tb/tb_trap_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap and interrupt sequencer for the user-mode CSR file. Picks the highest-priority
// retiring exception or pending interrupt, issues the CSR write, flush and redirect, and executes URET.
module trap_controller (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iInstrValid,
  input  logic [31:0] iPC,
  input  logic [31:0] iInstr,
  input  logic [31:0] iBadAddr,
  input  logic        iInstrMisal,
  input  logic        iIllegal,
  input  logic        iEbreak,
  input  logic        iEcall,
  input  logic        iLoadMisal,
  input  logic        iStoreMisal,
  input  logic        iUret,
  input  logic        iSoftInt,
  input  logic        iTimerInt,
  input  logic        iExtInt,
  input  logic [31:0] iUSTATUS,
  input  logic [31:0] iUTVEC,
  input  logic [31:0] iUEPC,
  output logic        oCSRWriteSimu,
  output logic [31:0] oUEPC,
  output logic [31:0] oUCAUSE,
  output logic [31:0] oUTVAL,
  output logic        oRedirect,
  output logic [31:0] oRedirectPC,
  output logic        oFlush,
  output logic        oStall,
  output logic [2:0]  oPending
);

  typedef enum logic [1:0] {IDLE, SAVE, HOLD} state_t;

  state_t      r_state;
  logic [2:0]  r_req_d;

  logic [2:0]  w_req;
  logic [2:0]  w_edge;
  logic [2:0]  w_clr;
  logic        w_uie;
  logic        w_trap;
  logic        w_is_int;
  logic        w_uret;
  logic [31:0] w_cause;
  logic [31:0] w_tval;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic        w_unused;

  // Pending bit order is {ext, timer, soft}.
  assign w_req    = {iExtInt, iTimerInt, iSoftInt};
  assign w_edge   = w_req & ~r_req_d;
  assign w_uie    = iUSTATUS[0];
  assign w_unused = ^iUSTATUS[31:1];

  // NOTE: every signal gets a default before the priority chain so no path infers a latch.
  always_comb begin
    w_trap   = 1'b0;
    w_is_int = 1'b0;
    w_uret   = 1'b0;
    w_clr    = 3'b000;
    w_cause  = 32'h0;
    w_tval   = 32'h0;
    if (r_state == IDLE && iInstrValid) begin
      if (w_uie && oPending[2]) begin
        w_trap = 1'b1; w_is_int = 1'b1; w_clr = 3'b100; w_cause = 32'h8000_0008;
      end else if (w_uie && oPending[0]) begin
        w_trap = 1'b1; w_is_int = 1'b1; w_clr = 3'b001; w_cause = 32'h8000_0000;
      end else if (w_uie && oPending[1]) begin
        w_trap = 1'b1; w_is_int = 1'b1; w_clr = 3'b010; w_cause = 32'h8000_0004;
      end else if (iInstrMisal) begin
        w_trap = 1'b1; w_cause = 32'd0; w_tval = iBadAddr;
      end else if (iIllegal) begin
        w_trap = 1'b1; w_cause = 32'd2; w_tval = iInstr;
      end else if (iEbreak) begin
        w_trap = 1'b1; w_cause = 32'd3;
      end else if (iEcall) begin
        w_trap = 1'b1; w_cause = 32'd8;
      end else if (iStoreMisal) begin
        w_trap = 1'b1; w_cause = 32'd6; w_tval = iBadAddr;
      end else if (iLoadMisal) begin
        w_trap = 1'b1; w_cause = 32'd4; w_tval = iBadAddr;
      end else if (iUret) begin
        w_uret = 1'b1;
      end
    end
  end

  // Vectored mode only applies to interrupts; modes 2 and 3 fall back to direct.
  assign w_base   = {iUTVEC[31:2], 2'b00};
  assign w_target = (iUTVEC[1:0] == 2'b01 && w_is_int) ?
                    w_base + {26'h0, w_cause[3:0], 2'b00} : w_base;

  // NOTE: state and registered outputs use non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state       <= IDLE;
      r_req_d       <= 3'b000;
      oPending      <= 3'b000;
      oCSRWriteSimu <= 1'b0;
      oRedirect     <= 1'b0;
      oFlush        <= 1'b0;
      oStall        <= 1'b0;
      oUEPC         <= 32'h0;
      oUCAUSE       <= 32'h0;
      oUTVAL        <= 32'h0;
      oRedirectPC   <= 32'h0;
    end else begin
      r_req_d       <= w_req;
      // A new edge is ORed in after the clear, so set wins over a same-cycle take.
      oPending      <= (oPending & ~w_clr) | w_edge;
      oCSRWriteSimu <= 1'b0;
      oRedirect     <= 1'b0;
      oFlush        <= 1'b0;
      case (r_state)
        IDLE: begin
          oStall <= w_trap;
          if (w_trap) begin
            r_state       <= SAVE;
            oCSRWriteSimu <= 1'b1;
            oRedirect     <= 1'b1;
            oFlush        <= 1'b1;
            oUEPC         <= iPC;
            oUCAUSE       <= w_cause;
            oUTVAL        <= w_tval;
            oRedirectPC   <= w_target;
          end else if (w_uret) begin
            oRedirect     <= 1'b1;
            oRedirectPC   <= iUEPC;
          end
        end
        SAVE: begin
          r_state <= HOLD;
          oStall  <= 1'b1;
        end
        HOLD: begin
          r_state <= IDLE;
          oStall  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          oStall  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-count behavioural model.
module tb_trap_controller;

  logic        iCLK, iRST, iInstrValid;
  logic [31:0] iPC, iInstr, iBadAddr;
  logic        iInstrMisal, iIllegal, iEbreak, iEcall, iLoadMisal, iStoreMisal, iUret;
  logic        iSoftInt, iTimerInt, iExtInt;
  logic [31:0] iUSTATUS, iUTVEC, iUEPC;
  logic        oCSRWriteSimu, oRedirect, oFlush, oStall;
  logic [31:0] oUEPC, oUCAUSE, oUTVAL, oRedirectPC;
  logic [2:0]  oPending;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  trap_controller dut (
    .iCLK(iCLK), .iRST(iRST), .iInstrValid(iInstrValid), .iPC(iPC), .iInstr(iInstr),
    .iBadAddr(iBadAddr), .iInstrMisal(iInstrMisal), .iIllegal(iIllegal), .iEbreak(iEbreak),
    .iEcall(iEcall), .iLoadMisal(iLoadMisal), .iStoreMisal(iStoreMisal), .iUret(iUret),
    .iSoftInt(iSoftInt), .iTimerInt(iTimerInt), .iExtInt(iExtInt), .iUSTATUS(iUSTATUS),
    .iUTVEC(iUTVEC), .iUEPC(iUEPC), .oCSRWriteSimu(oCSRWriteSimu), .oUEPC(oUEPC),
    .oUCAUSE(oUCAUSE), .oUTVAL(oUTVAL), .oRedirect(oRedirect), .oRedirectPC(oRedirectPC),
    .oFlush(oFlush), .oStall(oStall), .oPending(oPending)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Events indexed by priority: 0 ext, 1 soft, 2 timer, 3 instr-misal, 4 illegal,
  // 5 ebreak, 6 ecall, 7 store-misal, 8 load-misal, 9 uret.
  logic [31:0] k_cause [0:8] = '{32'h8000_0008, 32'h8000_0000, 32'h8000_0004,
                                 32'd0, 32'd2, 32'd3, 32'd8, 32'd6, 32'd4};
  int          m_busy;
  logic [2:0]  m_pend, m_prev, m_req, m_clr;
  logic [9:0]  m_ev;
  int          m_sel;
  logic [31:0] m_base;
  logic        e_csr, e_redirect, e_flush, e_stall;
  logic [31:0] e_uepc, e_ucause, e_utval, e_rpc;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_busy = 0; m_pend = 3'b000; m_prev = 3'b000;
      e_csr = 0; e_redirect = 0; e_flush = 0; e_stall = 0;
      e_uepc = 0; e_ucause = 0; e_utval = 0; e_rpc = 0;
    end else begin
      m_req = {iExtInt, iTimerInt, iSoftInt};
      m_clr = 3'b000;
      e_csr = 0; e_redirect = 0; e_flush = 0;
      m_sel = -1;
      if (m_busy == 0 && iInstrValid) begin
        m_ev = {iUret, iLoadMisal, iStoreMisal, iEcall, iEbreak, iIllegal, iInstrMisal,
                iUSTATUS[0] & m_pend[1], iUSTATUS[0] & m_pend[0], iUSTATUS[0] & m_pend[2]};
        for (int i = 9; i >= 0; i--) if (m_ev[i]) m_sel = i;
      end
      if (m_busy > 0) m_busy--;
      if (m_sel >= 0 && m_sel <= 8) begin
        m_busy   = 2;
        e_csr    = 1; e_redirect = 1; e_flush = 1;
        e_uepc   = iPC;
        e_ucause = k_cause[m_sel];
        e_utval  = (m_sel == 3 || m_sel == 7 || m_sel == 8) ? iBadAddr :
                   (m_sel == 4) ? iInstr : 32'h0;
        m_base   = iUTVEC & 32'hFFFF_FFFC;
        e_rpc    = (m_sel <= 2 && iUTVEC[1:0] == 2'b01) ? m_base + 4 * (e_ucause & 32'hF) : m_base;
        if (m_sel == 0) m_clr = 3'b100;
        if (m_sel == 1) m_clr = 3'b001;
        if (m_sel == 2) m_clr = 3'b010;
      end else if (m_sel == 9) begin
        e_redirect = 1;
        e_rpc      = iUEPC;
      end
      e_stall = (m_busy > 0);
      m_pend  = (m_pend & ~m_clr) | (m_req & ~m_prev);
      m_prev  = m_req;
    end
  end

  always @(negedge iCLK) begin
    if (cmp_en) begin
      check("csr_write", {31'h0, oCSRWriteSimu}, {31'h0, e_csr});
      check("redirect",  {31'h0, oRedirect},     {31'h0, e_redirect});
      check("flush",     {31'h0, oFlush},        {31'h0, e_flush});
      check("stall",     {31'h0, oStall},        {31'h0, e_stall});
      check("pending",   {29'h0, oPending},      {29'h0, m_pend});
      check("uepc",      oUEPC,       e_uepc);
      check("ucause",    oUCAUSE,     e_ucause);
      check("utval",     oUTVAL,      e_utval);
      check("redir_pc",  oRedirectPC, e_rpc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge iCLK);
    #2;
  endtask

  task automatic idle_inputs();
    iInstrValid = 0; iInstrMisal = 0; iIllegal = 0; iEbreak = 0; iEcall = 0;
    iLoadMisal = 0; iStoreMisal = 0; iUret = 0;
  endtask

  initial begin
    iRST = 1; iPC = 0; iInstr = 0; iBadAddr = 0; iUSTATUS = 0; iUTVEC = 0; iUEPC = 0;
    iSoftInt = 0; iTimerInt = 0; iExtInt = 0;
    idle_inputs();
    #1 cmp_en = 1'b1;
    @(negedge iCLK);
    check("rst_stall",   {31'h0, oStall},   32'h0);
    check("rst_pending", {29'h0, oPending}, 32'h0);
    next_cycle();
    iRST = 0;
    next_cycle();

    // Illegal instruction, direct mode.
    iUTVEC = 32'h0040_0100; iPC = 32'h0040_0010; iInstr = 32'hFFFF_FFFF;
    iIllegal = 1; iInstrValid = 1;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("ill_csr",   {31'h0, oCSRWriteSimu}, 32'h1);
    check("ill_uepc",  oUEPC,       32'h0040_0010);
    check("ill_cause", oUCAUSE,     32'h2);
    check("ill_tval",  oUTVAL,      32'hFFFF_FFFF);
    check("ill_pc",    oRedirectPC, 32'h0040_0100);
    check("ill_stall1", {31'h0, oStall}, 32'h1);
    next_cycle(); @(negedge iCLK);
    check("ill_csr_off", {31'h0, oCSRWriteSimu}, 32'h0);
    check("ill_stall2",  {31'h0, oStall},        32'h1);
    next_cycle(); @(negedge iCLK);
    check("ill_stall_end", {31'h0, oStall}, 32'h0);
    next_cycle();

    // Vectored timer interrupt.
    iUSTATUS = 32'h1; iUTVEC = 32'h0040_0101; iTimerInt = 1;
    next_cycle(); @(negedge iCLK);
    check("tmr_pend", {29'h0, oPending}, 32'h2);
    iInstrValid = 1; iPC = 32'h0040_0040;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("tmr_cause", oUCAUSE,     32'h8000_0004);
    check("tmr_pc",    oRedirectPC, 32'h0040_0110);
    check("tmr_clr",   {29'h0, oPending}, 32'h0);
    iTimerInt = 0;
    repeat (3) next_cycle();

    // External interrupt masked, then unmasked.
    iUSTATUS = 32'h0; iExtInt = 1; iInstrValid = 1; iPC = 32'h0040_0060;
    repeat (3) next_cycle();
    @(negedge iCLK);
    check("ext_masked_pend", {29'h0, oPending}, 32'h4);
    check("ext_masked_csr",  {31'h0, oCSRWriteSimu}, 32'h0);
    iUSTATUS = 32'h1;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("ext_cause", oUCAUSE, 32'h8000_0008);
    check("ext_csr",   {31'h0, oCSRWriteSimu}, 32'h1);
    iExtInt = 0;
    repeat (3) next_cycle();

    // Ext interrupt beats ecall; ecall retried at the earliest slot.
    iExtInt = 1;
    next_cycle();
    iInstrValid = 1; iEcall = 1; iPC = 32'h0040_0080;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("pri_cause", oUCAUSE, 32'h8000_0008);
    check("pri_uepc",  oUEPC,   32'h0040_0080);
    iExtInt = 0;
    next_cycle(); next_cycle();
    iInstrValid = 1; iEcall = 1; iPC = 32'h0040_0084;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("ecall_cause", oUCAUSE,     32'h8);
    check("ecall_uepc",  oUEPC,       32'h0040_0084);
    check("ecall_pc",    oRedirectPC, 32'h0040_0100);
    repeat (3) next_cycle();

    // URET.
    iUEPC = 32'h0040_0020; iUret = 1; iInstrValid = 1;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("uret_redirect", {31'h0, oRedirect},     32'h1);
    check("uret_pc",       oRedirectPC,            32'h0040_0020);
    check("uret_csr",      {31'h0, oCSRWriteSimu}, 32'h0);
    check("uret_flush",    {31'h0, oFlush},        32'h0);
    next_cycle(); @(negedge iCLK);
    check("uret_single", {31'h0, oRedirect}, 32'h0);
    next_cycle();

    // Reset while in SAVE with a masked soft interrupt pending.
    iUSTATUS = 32'h0; iSoftInt = 1;
    iIllegal = 1; iInstrValid = 1; iPC = 32'h0040_0100;
    next_cycle(); idle_inputs();
    iRST = 1;
    #1;
    check("rst_async_csr",      {31'h0, oCSRWriteSimu}, 32'h0);
    check("rst_async_redirect", {31'h0, oRedirect},     32'h0);
    check("rst_async_stall",    {31'h0, oStall},        32'h0);
    check("rst_async_pending",  {29'h0, oPending},      32'h0);
    check("rst_async_cause",    oUCAUSE,                32'h0);
    next_cycle();
    iRST = 0; iSoftInt = 0;
    next_cycle();
    iEbreak = 1; iInstrValid = 1; iPC = 32'h0040_0200;
    next_cycle(); idle_inputs();
    @(negedge iCLK);
    check("post_rst_csr",   {31'h0, oCSRWriteSimu}, 32'h1);
    check("post_rst_cause", oUCAUSE,                32'h3);
    repeat (3) next_cycle();

    // Randomized traffic, checked by the model every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      iRST        = ($urandom_range(0, 399) == 0);
      iInstrValid = $urandom_range(0, 1);
      iPC         = $urandom; iInstr = $urandom; iBadAddr = $urandom; iUEPC = $urandom;
      iInstrMisal = ($urandom_range(0, 11) == 0);
      iIllegal    = ($urandom_range(0, 11) == 0);
      iEbreak     = ($urandom_range(0, 11) == 0);
      iEcall      = ($urandom_range(0, 11) == 0);
      iLoadMisal  = ($urandom_range(0, 11) == 0);
      iStoreMisal = ($urandom_range(0, 11) == 0);
      iUret       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) iSoftInt  = ~iSoftInt;
      if ($urandom_range(0, 7) == 0) iTimerInt = ~iTimerInt;
      if ($urandom_range(0, 7) == 0) iExtInt   = ~iExtInt;
      if ($urandom_range(0, 19) == 0) iUSTATUS = $urandom;
      if ($urandom_range(0, 15) == 0) iUTVEC   = $urandom;
      next_cycle();
    end
    iRST = 0;
    idle_inputs();
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
